// File: rtl/led_pkg.sv
// Shared types and saturating fade helpers for the LED fade output stage.
`timescale 1ns/1ps
package led_pkg;

    localparam int N_LED  = 8;
    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    // Channel state is derived each cycle from duty versus target; it is never stored.
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_RISE = 2'd1,
        CH_ON   = 2'd2,
        CH_FALL = 2'd3
    } ch_state_t;

    // Rising step: min(duty + step, target), computed 9 bits wide so it cannot wrap.
    function automatic duty_t rise_sat(input duty_t duty, input duty_t target, input logic [8:0] step);
        logic [8:0] sum;
        sum = {1'b0, duty} + step;
        if (sum >= {1'b0, target}) begin
            return target;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Falling step: max(duty - step, target), compared 9 bits wide so it cannot underflow.
    function automatic duty_t fall_sat(input duty_t duty, input duty_t target, input logic [8:0] step);
        logic [8:0] floor9;
        floor9 = {1'b0, target} + step;
        if ({1'b0, duty} >= floor9) begin
            return duty - step[7:0];
        end else begin
            return target;
        end
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: duty register, saturating fade step toward target, PWM comparator.
`timescale 1ns/1ps
module led_fade_channel
    import led_pkg::*;
#(
    parameter int FADE_STEP = 8
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  en,
    input  logic  step,
    input  duty_t pwm_cnt,
    input  duty_t target,
    output logic  pwm_out,
    output logic  busy_ch
);

    localparam logic [8:0] STEP9 = 9'(FADE_STEP);

    duty_t     duty_r;
    duty_t     duty_nxt_s;
    ch_state_t state_s;
    logic      pwm_out_r;

    // Classify the channel from the current duty and its target.
    always_comb begin
        state_s = CH_OFF;
        if (duty_r < target) begin
            state_s = CH_RISE;
        end else if (duty_r > target) begin
            state_s = CH_FALL;
        end else if (duty_r != 8'd0) begin
            state_s = CH_ON;
        end else begin
            state_s = CH_OFF;
        end
    end

    // Next duty: only moves on a fade step, which always lands on a PWM period boundary.
    always_comb begin
        duty_nxt_s = duty_r;
        if (step) begin
            case (state_s)
                CH_RISE: duty_nxt_s = rise_sat(duty_r, target, STEP9);
                CH_FALL: duty_nxt_s = fall_sat(duty_r, target, STEP9);
                CH_ON:   duty_nxt_s = duty_r;
                CH_OFF:  duty_nxt_s = duty_r;
                default: duty_nxt_s = duty_r;
            endcase
        end else begin
            duty_nxt_s = duty_r;
        end
    end

    // Duty register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            duty_r <= 8'd0;
        end else begin
            duty_r <= duty_nxt_s;
        end
    end

    // Registered PWM output; forced low while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_out_r <= 1'b0;
        end else begin
            pwm_out_r <= en & (pwm_cnt < duty_r);
        end
    end

    assign pwm_out = pwm_out_r;
    assign busy_ch = (duty_r != target);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver top: input registers, prescaler, PWM/step counters, channel array, busy flag.
`timescale 1ns/1ps
module led_fade_driver
    import led_pkg::*;
#(
    parameter int PWM_DIV   = 2,
    parameter int STEP_DIV  = 4,
    parameter int FADE_STEP = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [7:0]       brightness,
    input  logic [7:0]       led_in,
    output logic [7:0]       led_out,
    output logic             busy
);

    localparam int PRE_W  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [N_LED-1:0]  led_q_r;
    duty_t             bri_q_r;
    logic [PRE_W-1:0]  pre_cnt_r;
    duty_t             pwm_cnt_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic              busy_r;

    logic              tick_s;
    logic              period_end_s;
    logic              step_s;
    duty_t             target_s [N_LED];
    logic [N_LED-1:0]  pwm_s;
    logic [N_LED-1:0]  busy_ch_s;

    assign tick_s       = en & (pre_cnt_r == PRE_W'(PWM_DIV - 1));
    assign period_end_s = tick_s & (pwm_cnt_r == 8'd255);
    assign step_s       = period_end_s & (step_cnt_r == STEP_W'(STEP_DIV - 1));

    // Register the pattern and brightness once; everything downstream uses these copies.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q_r <= 8'd0;
            bri_q_r <= 8'd0;
        end else begin
            led_q_r <= led_in;
            bri_q_r <= brightness;
        end
    end

    // Prescaler: divides clk down to PWM counter ticks; frozen while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt_r <= '0;
        end else if (en) begin
            if (tick_s) begin
                pre_cnt_r <= '0;
            end else begin
                pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            end
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

    // 8-bit PWM counter, wraps 255 -> 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt_r <= 8'd0;
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Counts PWM periods between fade steps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_cnt_r <= '0;
        end else if (period_end_s) begin
            if (step_s) begin
                step_cnt_r <= '0;
            end else begin
                step_cnt_r <= step_cnt_r + STEP_W'(1);
            end
        end else begin
            step_cnt_r <= step_cnt_r;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        assign target_s[i] = led_q_r[i] ? bri_q_r : 8'd0;

        led_fade_channel #(
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .en      (en),
            .step    (step_s),
            .pwm_cnt (pwm_cnt_r),
            .target  (target_s[i]),
            .pwm_out (pwm_s[i]),
            .busy_ch (busy_ch_s[i])
        );
    end

    // Busy flag: any channel still away from its target; tracks even while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |busy_ch_s;
        end
    end

    assign led_out = pwm_s;
    assign busy    = busy_r;

endmodule
